icache_dm: RTL
==============

# icache_dm

Direct-mapped instruction cache that answers the fetch stage's per-cycle instruction lookup and refills missing lines from backing instruction memory. Fetch drives a byte address every cycle and receives the instruction plus a stall indication. On a miss the cache stalls fetch, bursts one line from memory through a request/grant/data-valid handshake, installs it, and then serves the hit.

## Interface
- ADDR_BITS, 16, byte address width (matches fetch PC width)
- DATA_BITS, 16, instruction width
- LINES, 16, number of cache lines (power of two)
- WORDS, 4, instructions per line (power of two); one instruction per 4-byte address slot

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  ADDR_BITS  fetch address; addr[1:0] ignored
- instr  out  DATA_BITS  instruction at addr; 0 when instr_valid=0
- instr_valid  out  1  instr is a hit this cycle
- stall  out  1  fetch must hold PC; equals !instr_valid
- flush  in  1  invalidate all lines
- mem_req  out  1  line-refill request, held until granted
- mem_addr  out  ADDR_BITS  line base byte address of the request
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  mem_rdata carries the next word of the line
- mem_rdata  in  DATA_BITS  refill data, line words in ascending order

## Operation
- Address split: offset = addr[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- Storage: data array LINES x WORDS x DATA_BITS, tag array, valid bit per line. Only valid bits are reset.
- Hit (combinational): state IDLE, valid[index]=1, tag match -> instr_valid=1, instr=data[index][offset].
- FSM states: IDLE, REQ, FILL.
- IDLE: on miss, capture miss_addr <= addr, go REQ. A flush in the same cycle still clears valid bits; the miss proceeds.
- REQ: mem_req=1, mem_addr = miss_addr with offset and byte bits zeroed. mem_addr stable while mem_req=1. On mem_gnt: cnt <= 0, go FILL.
- FILL: each cycle with mem_rvalid, write mem_rdata to data[miss index][cnt], cnt++. Gaps (rvalid=0) allowed. On rvalid with cnt=WORDS-1: write tag, set valid[miss index], go IDLE.
- mem_rvalid outside FILL is ignored. mem_gnt outside REQ is ignored.
- instr_valid=0 in REQ and FILL regardless of addr (no hit-under-miss).
- addr changes during a refill (branch): refill completes for miss_addr; lookup resumes in IDLE with the new addr.
- Flush: clears all valid bits next edge, any state. Flush coinciding with the final FILL beat: flush wins, the line is left invalid. Flush earlier in REQ/FILL: refill completes and installs the line valid.
- Eviction: refill overwrites the line at miss index unconditionally (no dirty state).

## Timing
- Reset (rst_n=0, async): state IDLE, cnt=0, all valid=0, miss_addr=0, mem_req=0, mem_addr=0. Outputs during and right after reset: instr_valid=0, stall=1, instr=0.
- Hit latency: 0 cycles (same-cycle combinational).
- Miss at cycle T: stall=1 at T; REQ with mem_req=1 at T+1; gnt at G; beats at G+1 onward; final beat at F; IDLE at F+1 with hit, instr_valid=1 if addr unchanged.
- Minimum miss penalty (gnt at T+1, back-to-back rvalid): hit at T+2+WORDS (T+6 for WORDS=4).
- Reset mid-refill: immediate return to IDLE, mem_req drops asynchronously, partially written line stays invalid; later memory beats ignored.
- mem_req deasserts the cycle after mem_gnt.

## Test plan
- Cold miss: reset, addr=0x0010, gnt at T+1, beats 0xA000..0xA003 back-to-back -> mem_addr=0x0010, instr_valid=1 at T+6 with instr=0xA000.
- Line hits: after cold miss, addr 0x0014, 0x0018, 0x001C -> instr 0xA001, 0xA002, 0xA003 same cycle, no mem_req.
- Conflict eviction: fill 0x0010, then addr=0x0110 (same index, new tag) -> miss, refill with mem_addr=0x0110; return to 0x0010 -> miss again.
- Handshake stall: hold mem_gnt=0 for 5 cycles, then rvalid with 2-cycle gaps -> mem_req and mem_addr stable until gnt; data lands only on rvalid beats; stall=1 throughout.
- Flush: fill two lines, pulse flush -> both addresses miss; flush on final FILL beat -> same address misses again after IDLE.
- Reset mid-refill: assert rst_n=0 during FILL after 2 beats -> mem_req=0 immediately; after release addr of that line misses and refills fully.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hit lookup for fetch, line refill
// from backing memory through a req/gnt/rvalid burst on a miss.
module icache_dm #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned LINES     = 16,
  parameter int unsigned WORDS     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] instr,
  output logic                 instr_valid,
  output logic                 stall,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned LINE_W = ADDR_BITS - OFF_W - 2;
  localparam int unsigned TAG_W  = LINE_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t               state;
  logic [OFF_W-1:0]     cnt;
  logic [LINE_W-1:0]    miss_line;
  logic [LINES-1:0]     valid;
  logic [DATA_BITS-1:0] data_arr [LINES*WORDS];
  logic [TAG_W-1:0]     tag_arr  [LINES];

  logic [OFF_W-1:0]     off;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     miss_idx;
  logic [TAG_W-1:0]     miss_tag;
  logic                 hit;
  logic                 fill_beat;
  logic                 last_beat;
  logic                 unused_addr_bits;

  // Address decode for the live lookup and for the line being refilled
  assign off      = addr[OFF_W+1:2];
  assign idx      = addr[OFF_W+2 +: IDX_W];
  assign tag      = addr[ADDR_BITS-1 -: TAG_W];
  assign miss_idx = miss_line[IDX_W-1:0];
  assign miss_tag = miss_line[LINE_W-1 -: TAG_W];
  assign unused_addr_bits = ^addr[1:0];

  // Lookup is only honoured in IDLE: no hit-under-miss
  assign hit         = (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);
  assign instr_valid = hit;
  assign stall       = !hit;
  assign instr       = hit ? data_arr[{idx, off}] : '0;
  assign mem_addr    = {miss_line, {(OFF_W+2){1'b0}}};

  assign fill_beat = (state == FILL) && mem_rvalid;
  assign last_beat = fill_beat && (cnt == OFF_W'(WORDS-1));

  // Data and tag storage: written by refill beats, never reset
  always_ff @(posedge clk) begin
    if (fill_beat) data_arr[{miss_idx, cnt}] <= mem_rdata;
    if (last_beat) tag_arr[miss_idx] <= miss_tag;
  end

  // Refill controller, request register and per-line valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      miss_line <= '0;
      mem_req   <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            miss_line <= addr[ADDR_BITS-1:OFF_W+2];
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            cnt <= cnt + OFF_W'(1);
            if (last_beat) begin
              valid[miss_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Flush is applied last so it beats a line install on the same edge
      if (flush) valid <= '0;
    end
  end

endmodule
